// File: rtl/euler_state_update_if.sv
// Handshake and data bundle between the ODE row engines and the Euler update stage.
// The master side drives start/operands/bu; the slave side (the update stage) answers.
interface euler_state_update_if #(
    parameter int N = 3
);
    logic              start;
    logic [15:0]       h;
    logic [16*N-1:0]   X;
    logic [16*N-1:0]   AX;
    logic [15:0]       bu;
    logic              bu_valid;
    logic              bu_ready;
    logic [15:0]       row_idx;
    logic [16*N-1:0]   X_next;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, h, X, AX, bu, bu_valid,
        input  bu_ready, row_idx, X_next, busy, done, error
    );

    modport slave (
        input  start, h, X, AX, bu, bu_valid,
        output bu_ready, row_idx, X_next, busy, done, error
    );
endinterface

// File: rtl/euler_state_update.sv
// Forward-Euler row update: x_next[i] = x[i] + h*ax[i] + bu, rows consumed N-1 down to 0.
// Define SATURATE_EN to clamp overflowing operations instead of wrapping them.
module euler_state_update #(
    parameter int N    = 3,
    parameter int FRAC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    euler_state_update_if.slave   bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_FIN} state_t;

    state_t              r_state;
    logic signed [15:0]  r_h;
    logic [16*N-1:0]     r_x;
    logic [16*N-1:0]     r_ax;
    logic [15:0]         r_row_idx;
    logic [16*N-1:0]     r_x_next;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_bu_ready;

    logic signed [15:0]  w_x_rows  [N];
    logic signed [15:0]  w_ax_rows [N];
    logic [IDX_W-1:0]    w_row_sel;
    logic signed [15:0]  w_x;
    logic signed [15:0]  w_ax;
    logic signed [15:0]  w_bu;
    logic signed [31:0]  w_prod;
    logic [16-FRAC:0]    w_prod_hi;
    logic                w_mul_ovf;
    logic signed [15:0]  w_mul;
    logic signed [15:0]  w_s1;
    logic                w_add1_ovf;
    logic signed [15:0]  w_sum;
    logic                w_add2_ovf;
    logic                w_ovf;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rows
            assign w_x_rows[gi]  = r_x[16*gi +: 16];
            assign w_ax_rows[gi] = r_ax[16*gi +: 16];
        end
    endgenerate

    assign w_row_sel = r_row_idx[IDX_W-1:0];
    assign w_x       = w_x_rows[w_row_sel];
    assign w_ax      = w_ax_rows[w_row_sel];
    assign w_bu      = bus.bu;
    assign w_prod    = r_h * w_ax;
    assign w_prod_hi = w_prod[31:FRAC+15];
    // The product fits in 16 bits only when every bit above the kept window matches its sign.
    assign w_mul_ovf = !((&w_prod_hi) || !(|w_prod_hi));

    always_comb begin
        w_mul = w_prod[FRAC+15:FRAC];
`ifdef SATURATE_EN
        if (w_mul_ovf) w_mul = w_prod[31] ? 16'sh8000 : 16'sh7FFF;
`endif
        w_s1       = w_x + w_mul;
        w_add1_ovf = (w_x[15] == w_mul[15]) && (w_s1[15] != w_x[15]);
`ifdef SATURATE_EN
        if (w_add1_ovf) w_s1 = w_x[15] ? 16'sh8000 : 16'sh7FFF;
`endif
        w_sum      = w_s1 + w_bu;
        w_add2_ovf = (w_s1[15] == w_bu[15]) && (w_sum[15] != w_s1[15]);
`ifdef SATURATE_EN
        if (w_add2_ovf) w_sum = w_s1[15] ? 16'sh8000 : 16'sh7FFF;
`endif
        w_ovf = w_mul_ovf || w_add1_ovf || w_add2_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_h        <= '0;
            r_x        <= '0;
            r_ax       <= '0;
            r_row_idx  <= 16'(N-1);
            r_x_next   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_bu_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_h        <= bus.h;
                        r_x        <= bus.X;
                        r_ax       <= bus.AX;
                        r_error    <= 1'b0;
                        r_row_idx  <= 16'(N-1);
                        r_busy     <= 1'b1;
                        r_bu_ready <= 1'b1;
                        r_state    <= S_ROW;
                    end
                end
                S_ROW: begin
                    if (bus.bu_valid) begin
                        r_x_next[16*w_row_sel +: 16] <= w_sum;
                        if (w_ovf) r_error <= 1'b1;
                        if (r_row_idx == 16'd0) begin
                            r_busy     <= 1'b0;
                            r_bu_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_FIN;
                        end else begin
                            r_row_idx <= r_row_idx - 16'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bu_ready = r_bu_ready;
    assign bus.row_idx  = r_row_idx;
    assign bus.X_next   = r_x_next;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.error    = r_error;
endmodule

// File: tb/tb_euler_state_update.sv
// Scoreboard bench for euler_state_update: expected rows are queued as bu is driven
// and compared against X_next/error when done pulses.
module tb_euler_state_update;
    localparam int N    = 3;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    euler_state_update_if #(.N(N)) bus_if ();

    euler_state_update #(.N(N), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int          row;
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_xnext [N];
    logic        m_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fit16(input int v, output logic ovf);
        logic [31:0] t;
        logic        hi;
        logic        lo;
        t   = v;
        hi  = (v > 32767);
        lo  = (v < -32768);
        ovf = hi | lo;
`ifdef SATURATE_EN
        if (hi) return 16'h7FFF;
        if (lo) return 16'h8000;
`endif
        return t[15:0];
    endfunction

    function automatic logic [16:0] row_model(input logic [15:0] h, input logic [15:0] x,
                                              input logic [15:0] ax, input logic [15:0] bu);
        int          p;
        int          s;
        logic        o1, o2, o3;
        logic [15:0] m, s1, s2;
        p  = int'($signed(h)) * int'($signed(ax));
        m  = fit16(p >>> FRAC, o1);
        s  = int'($signed(x)) + int'($signed(m));
        s1 = fit16(s, o2);
        s  = int'($signed(s1)) + int'($signed(bu));
        s2 = fit16(s, o3);
        return {o1 | o2 | o3, s2};
    endfunction

    task automatic check_outputs(input string name);
        for (int i = 0; i < N; i++)
            check_val($sformatf("%s x_next[%0d]", name, i), 64'(bus_if.X_next[16*i +: 16]), 64'(m_xnext[i]));
        check_val({name, " error"}, 64'(bus_if.error), 64'(m_err));
    endtask

    task automatic run_update(input string name, input logic [15:0] h,
                              input logic [16*N-1:0] x, input logic [16*N-1:0] ax,
                              input logic [16*N-1:0] bu, input int stall_row,
                              input int stall_len, input bit glitch);
        int          edges;
        logic [16:0] res;
        exp_t        e;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.h     = h;
        bus_if.X     = x;
        bus_if.AX    = ax;
        @(negedge clk);
        edges        = 0;
        bus_if.start = glitch;
        if (glitch) begin
            bus_if.X  = ~x;
            bus_if.AX = ~ax;
            bus_if.h  = ~h;
        end
        check_val({name, " busy_start"}, 64'(bus_if.busy), 64'd1);
        check_val({name, " ready_start"}, 64'(bus_if.bu_ready), 64'd1);
        for (int r = N-1; r >= 0; r--) begin
            if (r == stall_row) begin
                bus_if.bu_valid = 1'b0;
                bus_if.bu       = 16'h5A5A;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    edges++;
                    check_val({name, " stall_row_idx"}, 64'(bus_if.row_idx), 64'(r));
                    check_val({name, " stall_busy"}, 64'(bus_if.busy), 64'd1);
                end
            end
            check_val({name, " row_idx"}, 64'(bus_if.row_idx), 64'(r));
            bus_if.bu       = bu[16*r +: 16];
            bus_if.bu_valid = 1'b1;
            res = row_model(h, x[16*r +: 16], ax[16*r +: 16], bu[16*r +: 16]);
            sb_q.push_back('{r, res[15:0], res[16]});
            @(negedge clk);
            edges++;
        end
        bus_if.bu_valid = 1'b0;
        bus_if.bu       = 16'(16'h1357 + edges);
        for (int k = 0; k < 16 && !bus_if.done; k++) begin
            @(negedge clk);
            edges++;
        end
        check_val({name, " done"}, 64'(bus_if.done), 64'd1);
        if (stall_len == 0)
            check_val({name, " done_latency"}, 64'(edges), 64'(N));
        check_val({name, " busy_fin"}, 64'(bus_if.busy), 64'd0);
        check_val({name, " ready_fin"}, 64'(bus_if.bu_ready), 64'd0);
        m_err = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            m_xnext[e.row] = e.val;
            m_err |= e.ovf;
        end
        check_outputs(name);
        $display("update %s h=%h X=%h AX=%h bu=%h -> X_next=%h error=%0d",
                 name, h, x, ax, bu, bus_if.X_next, bus_if.error);
        @(negedge clk);
        bus_if.start = 1'b0;
        check_val({name, " done_pulse"}, 64'(bus_if.done), 64'd0);
        check_val({name, " no_restart"}, 64'(bus_if.busy), 64'd0);
    endtask

    task automatic idle_bu_pulse();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_if.bu_valid = 1'b1;
            bus_if.bu       = 16'(16'h1234 + k);
            check_val("idle_bu done", 64'(bus_if.done), 64'd0);
        end
        @(negedge clk);
        bus_if.bu_valid = 1'b0;
        check_outputs("idle_bu");
        check_val("idle_bu busy", 64'(bus_if.busy), 64'd0);
        $display("idle bu_valid pulses -> X_next=%h", bus_if.X_next);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.h     = 16'h0080;
        bus_if.X     = {N{16'h0100}};
        bus_if.AX    = {N{16'h0200}};
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.bu       = 16'h0040;
        bus_if.bu_valid = 1'b1;
        @(negedge clk);
        bus_if.bu_valid = 1'b0;
        check_val("rst_mid row_idx_before", 64'(bus_if.row_idx), 64'(N-2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) m_xnext[i] = 16'h0000;
        m_err = 1'b0;
        sb_q.delete();
        check_outputs("rst_mid");
        check_val("rst_mid busy", 64'(bus_if.busy), 64'd0);
        check_val("rst_mid done", 64'(bus_if.done), 64'd0);
        check_val("rst_mid row_idx", 64'(bus_if.row_idx), 64'(N-1));
        check_val("rst_mid ready", 64'(bus_if.bu_ready), 64'd0);
        $display("reset mid-update -> X_next=%h row_idx=%0d", bus_if.X_next, bus_if.row_idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*N-1:0] rx, rax, rbu;
        bus_if.start    = 1'b0;
        bus_if.h        = '0;
        bus_if.X        = '0;
        bus_if.AX       = '0;
        bus_if.bu       = '0;
        bus_if.bu_valid = 1'b0;
        for (int i = 0; i < N; i++) m_xnext[i] = 16'h0000;
        m_err = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs("reset");
        check_val("reset busy", 64'(bus_if.busy), 64'd0);
        check_val("reset done", 64'(bus_if.done), 64'd0);
        check_val("reset ready", 64'(bus_if.bu_ready), 64'd0);
        check_val("reset row_idx", 64'(bus_if.row_idx), 64'(N-1));
        rst = 1'b0;

        run_update("T1", 16'h0080, {N{16'h0100}}, {N{16'h0200}}, {N{16'h0040}}, -1, 0, 1'b0);
        run_update("T2", 16'h0100, {16'h7000, 16'h0100, 16'h0100},
                   {16'h2000, 16'h0100, 16'h0100}, {N{16'h0000}}, -1, 0, 1'b0);
        run_update("T3", 16'h0080, {N{16'h0100}}, {N{16'h0200}}, {N{16'h0040}}, 1, 5, 1'b0);
        run_update("T4", 16'h0100, {16'h0300, 16'h0200, 16'h0100},
                   {16'h0010, 16'h0020, 16'h0030}, {16'h0001, 16'h0002, 16'h0003}, -1, 0, 1'b1);
        idle_bu_pulse();
        run_update("T6", 16'h0100, {N{16'hFF00}}, {N{16'hFE00}}, {N{16'hFF80}}, -1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                rx[16*i +: 16]  = 16'($urandom);
                rax[16*i +: 16] = 16'($urandom);
                rbu[16*i +: 16] = 16'($urandom);
            end
            run_update($sformatf("RND%0d", t), 16'($urandom_range(0, 16'hFFFF)),
                       rx, rax, rbu, (t % 2 == 1) ? t % N : -1, (t % 2 == 1) ? 2 : 0, 1'b0);
        end

        reset_mid();
        run_update("T5_fresh", 16'h0080, {N{16'h0100}}, {N{16'h0200}}, {N{16'h0040}}, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
